rvseed_test_mon: RTL and testbench

- Synthesizable end-of-test monitor that snoops the rvseed register-file write port.
- Decides pass, fail or timeout from the riscv-tests convention:
  - x26 = 1 marks end of test.
  - x27 = 1 marks pass.
  - x3 holds the current test number.
- Sits directly downstream of the rvseed core, beside u_reg_file_0, fed by the same write-port signals.
- Gives benches and FPGA builds a registered status instead of hierarchical peeks into reg_f.

---
 rtl/rvseed_test_mon_pkg.sv | 23 ++
 rtl/rvseed_test_mon_sat_cnt.sv | 27 ++
 rtl/rvseed_test_mon.sv | 86 ++++++++
 tb/tb_rvseed_test_mon.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvseed_test_mon_pkg.sv
// Shared register numbers, data width and monitor state encodings for rvseed_test_mon.
// Snoops the write port only, so there is no latency or backpressure of its own.
package rvseed_test_mon_pkg;

  localparam int CPU_WIDTH = 32;

  localparam logic [4:0] REG_GP  = 5'd3;
  localparam logic [4:0] REG_S10 = 5'd26;
  localparam logic [4:0] REG_S11 = 5'd27;

  typedef enum logic [2:0] {
    MON_RUN   = 3'd0,
    MON_DRAIN = 3'd1,
    MON_PASS  = 3'd2,
    MON_FAIL  = 3'd3,
    MON_TMO   = 3'd4
  } mon_state_e;

  function automatic logic is_terminal(input mon_state_e s);
    return (s == MON_PASS) || (s == MON_FAIL) || (s == MON_TMO);
  endfunction

endpackage

// File: rtl/rvseed_test_mon_sat_cnt.sv
// Saturating up-counter with sync clear and a registered-value match flag.
// One edge per increment; no backpressure, it simply stops at all-ones.
module rvseed_test_mon_sat_cnt #(
  parameter int          W     = 32,
  parameter logic [W-1:0] MATCH = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         hit
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !(&cnt)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign hit = (cnt == MATCH);

endmodule

// File: rtl/rvseed_test_mon.sv
// End-of-test monitor: x26=1 ends the test, x27 decides pass/fail, x3 is the test number.
// Status asserts two edges after the x26 write; snoop only, never stalls the core.
module rvseed_test_mon
  import rvseed_test_mon_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 rf_wen,
  input  logic [4:0]           rf_waddr,
  input  logic [CPU_WIDTH-1:0] rf_wdata,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [CPU_WIDTH-1:0] fail_testnum,
  output logic [CNT_W-1:0]     cycle_cnt
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mon_state_e           state_q, state_d;
  logic [CPU_WIDTH-1:0] shadow_x3, shadow_x27;
  logic [CPU_WIDTH-1:0] eff_x3, eff_x27;
  logic                 wr_x3, wr_x27, end_trig, live, tmo_hit;

  assign live = (state_q == MON_RUN) || (state_q == MON_DRAIN);

  rvseed_test_mon_sat_cnt #(
    .W     (CNT_W),
    .MATCH (TMO_LAST)
  ) u_sat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (live),
    .cnt   (cycle_cnt),
    .hit   (tmo_hit)
  );

  // Same-edge writes bypass the shadows so the DRAIN decision sees them.
  always_comb begin
    wr_x3    = rf_wen && (rf_waddr == REG_GP);
    wr_x27   = rf_wen && (rf_waddr == REG_S11);
    end_trig = rf_wen && (rf_waddr == REG_S10) && (rf_wdata == CPU_WIDTH'(1));
    eff_x3   = wr_x3  ? rf_wdata : shadow_x3;
    eff_x27  = wr_x27 ? rf_wdata : shadow_x27;
    state_d  = state_q;
    case (state_q)
      MON_RUN: begin
        if (end_trig)     state_d = MON_DRAIN;
        else if (tmo_hit) state_d = MON_TMO;
      end
      MON_DRAIN: state_d = (eff_x27 == CPU_WIDTH'(1)) ? MON_PASS : MON_FAIL;
      default:   state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MON_RUN;
      shadow_x3    <= '0;
      shadow_x27   <= '0;
      fail_testnum <= '0;
    end else if (clr) begin
      state_q      <= MON_RUN;
      shadow_x3    <= '0;
      shadow_x27   <= '0;
      fail_testnum <= '0;
    end else begin
      state_q <= state_d;
      if (live && wr_x3)  shadow_x3  <= rf_wdata;
      if (live && wr_x27) shadow_x27 <= rf_wdata;
      if (live && is_terminal(state_d)) fail_testnum <= eff_x3;
    end
  end

  assign done    = is_terminal(state_q);
  assign pass    = (state_q == MON_PASS);
  assign fail    = (state_q == MON_FAIL);
  assign timeout = (state_q == MON_TMO);

endmodule

// File: tb/tb_rvseed_test_mon.sv
// Randomised and directed checks of rvseed_test_mon against an event-list reference model.
module tb_rvseed_test_mon;

  localparam int TMO = 20;
  localparam int RUN_EDGES = 24;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        clr = 0;
  logic        rf_wen = 0;
  logic [4:0]  rf_waddr = 0;
  logic [31:0] rf_wdata = 0;
  logic        done, pass, fail, timeout;
  logic [31:0] fail_testnum;
  logic [31:0] cycle_cnt;

  int n_vec = 0;
  int n_err = 0;
  wr_t seq[$];

  rvseed_test_mon #(.TIMEOUT_CYC(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_testnum(fail_testnum), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] flags();
    return {done, pass, fail, timeout};
  endfunction

  task automatic do_reset();
    rst_n = 0; clr = 0; rf_wen = 0; rf_waddr = 0; rf_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  // Drive one write (or idle) for the next edge, then return at the following negedge.
  task automatic step(input logic wen, input logic [4:0] addr, input logic [31:0] data);
    rf_wen = wen; rf_waddr = addr; rf_wdata = data;
    @(posedge clk);
    @(negedge clk);
    rf_wen = 0; rf_waddr = 0; rf_wdata = 0;
  endtask

  function automatic wr_t ent(input int k);
    wr_t e;
    e.wen = 0; e.addr = 0; e.data = 0;
    if (k >= 1 && k <= seq.size()) e = seq[k-1];
    return e;
  endfunction

  // Outcome derived from the write list: seq[k-1] lands on edge k after reset.
  task automatic model(output logic [3:0] f, output logic [31:0] tn, output logic [31:0] cnt);
    logic [31:0] x3, x27;
    wr_t e;
    x3 = 0; x27 = 0;
    for (int k = 1; k <= TMO; k++) begin
      e = ent(k);
      if (e.wen && e.addr == 5'd3)  x3  = e.data;
      if (e.wen && e.addr == 5'd27) x27 = e.data;
      if (e.wen && e.addr == 5'd26 && e.data == 32'd1) begin
        e = ent(k + 1);
        if (e.wen && e.addr == 5'd3)  x3  = e.data;
        if (e.wen && e.addr == 5'd27) x27 = e.data;
        f   = (x27 == 32'd1) ? 4'b1100 : 4'b1010;
        tn  = x3;
        cnt = k + 1;
        return;
      end
    end
    f = 4'b1001; tn = x3; cnt = TMO;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (flags() !== 4'b0000 || fail_testnum !== 0 || cycle_cnt !== 0) begin
      n_err++;
      $display("FAIL reset: flags=%b tn=%0d cnt=%0d, want 0000/0/0", flags(), fail_testnum, cycle_cnt);
    end
  endtask

  task automatic test_pass();
    do_reset();
    step(1, 3, 5); step(1, 27, 1); step(1, 26, 1);
    n_vec++;
    if (flags() !== 4'b0000) begin
      n_err++; $display("FAIL pass_drain: flags=%b want 0000", flags());
    end
    step(0, 0, 0);
    n_vec++;
    if (flags() !== 4'b1100 || fail_testnum !== 5 || cycle_cnt !== 4) begin
      n_err++;
      $display("FAIL pass_decide: flags=%b tn=%0d cnt=%0d want 1100/5/4", flags(), fail_testnum, cycle_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      step(1, 5'(i % 2 ? 27 : 3), 32'(i));
      n_vec++;
      if (flags() !== 4'b1100 || fail_testnum !== 5 || cycle_cnt !== 4) begin
        n_err++;
        $display("FAIL pass_hold%0d: flags=%b tn=%0d cnt=%0d want 1100/5/4", i, flags(), fail_testnum, cycle_cnt);
      end
    end
  endtask

  task automatic test_fail();
    do_reset();
    step(1, 3, 7); step(1, 27, 0); step(1, 26, 1); step(0, 0, 0);
    n_vec++;
    if (flags() !== 4'b1010 || fail_testnum !== 7) begin
      n_err++; $display("FAIL fail_decide: flags=%b tn=%0d want 1010/7", flags(), fail_testnum);
    end
    step(1, 27, 1); step(1, 3, 3); step(0, 0, 0);
    n_vec++;
    if (flags() !== 4'b1010 || fail_testnum !== 7 || cycle_cnt !== 4) begin
      n_err++;
      $display("FAIL fail_sticky: flags=%b tn=%0d cnt=%0d want 1010/7/4", flags(), fail_testnum, cycle_cnt);
    end
  endtask

  task automatic test_drain_capture();
    do_reset();
    step(1, 27, 0); step(1, 26, 1); step(1, 27, 1);
    n_vec++;
    if (flags() !== 4'b1100) begin
      n_err++; $display("FAIL drain_capture: flags=%b want 1100", flags());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (TMO - 1) step(0, 0, 0);
    n_vec++;
    if (flags() !== 4'b0000 || cycle_cnt !== TMO - 1) begin
      n_err++; $display("FAIL tmo_before: flags=%b cnt=%0d want 0000/%0d", flags(), cycle_cnt, TMO - 1);
    end
    step(0, 0, 0);
    n_vec++;
    if (flags() !== 4'b1001 || cycle_cnt !== TMO || fail_testnum !== 0) begin
      n_err++;
      $display("FAIL tmo_edge: flags=%b cnt=%0d tn=%0d want 1001/%0d/0", flags(), cycle_cnt, fail_testnum, TMO);
    end
    step(1, 26, 1); repeat (4) step(0, 0, 0);
    n_vec++;
    if (flags() !== 4'b1001 || cycle_cnt !== TMO) begin
      n_err++; $display("FAIL tmo_frozen: flags=%b cnt=%0d want 1001/%0d", flags(), cycle_cnt, TMO);
    end
  endtask

  task automatic test_filter();
    do_reset();
    step(1, 26, 2); step(0, 26, 1); step(1, 0, 1); step(0, 0, 0); step(0, 0, 0);
    n_vec++;
    if (flags() !== 4'b0000 || cycle_cnt !== 5) begin
      n_err++; $display("FAIL filter: flags=%b cnt=%0d want 0000/5", flags(), cycle_cnt);
    end
    step(1, 26, 1); step(0, 0, 0);
    n_vec++;
    if (flags() !== 4'b1010) begin
      n_err++; $display("FAIL filter_then_end: flags=%b want 1010", flags());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1, 27, 1); step(1, 26, 1);
    rst_n = 0;
    #2;
    n_vec++;
    if (flags() !== 4'b0000 || cycle_cnt !== 0 || fail_testnum !== 0) begin
      n_err++; $display("FAIL rst_mid: flags=%b cnt=%0d want 0000/0", flags(), cycle_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    step(0, 0, 0); step(0, 0, 0);
    n_vec++;
    if (flags() !== 4'b0000 || cycle_cnt !== 2) begin
      n_err++; $display("FAIL rst_restart: flags=%b cnt=%0d want 0000/2", flags(), cycle_cnt);
    end
    step(1, 3, 11); step(1, 27, 1); step(1, 26, 1); step(0, 0, 0);
    n_vec++;
    if (flags() !== 4'b1100 || fail_testnum !== 11) begin
      n_err++; $display("FAIL rst_repass: flags=%b tn=%0d want 1100/11", flags(), fail_testnum);
    end
  endtask

  task automatic test_clr();
    do_reset();
    step(1, 3, 4); step(1, 27, 1); step(1, 26, 1); step(0, 0, 0);
    clr = 1;
    step(1, 3, 8);
    clr = 0;
    n_vec++;
    if (flags() !== 4'b0000 || cycle_cnt !== 0 || fail_testnum !== 0) begin
      n_err++;
      $display("FAIL clr: flags=%b cnt=%0d tn=%0d want 0000/0/0", flags(), cycle_cnt, fail_testnum);
    end
    step(1, 27, 0); step(1, 26, 1); step(0, 0, 0);
    n_vec++;
    if (flags() !== 4'b1010 || fail_testnum !== 0 || cycle_cnt !== 3) begin
      n_err++;
      $display("FAIL clr_rerun: flags=%b tn=%0d cnt=%0d want 1010/0/3", flags(), fail_testnum, cycle_cnt);
    end
  endtask

  task automatic test_random();
    logic [3:0]  ef;
    logic [31:0] etn, ecnt;
    wr_t w;
    for (int it = 0; it < 40; it++) begin
      seq.delete();
      for (int j = 0; j < int'($urandom_range(2, 22)); j++) begin
        w.wen = ($urandom_range(0, 4) != 0);
        case ($urandom_range(0, 5))
          0: w.addr = 5'd0;
          1: w.addr = 5'd3;
          2: w.addr = 5'd26;
          3: w.addr = 5'd27;
          default: w.addr = 5'($urandom_range(0, 31));
        endcase
        w.data = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 2));
        seq.push_back(w);
      end
      model(ef, etn, ecnt);
      do_reset();
      for (int k = 1; k <= RUN_EDGES; k++) begin
        w = ent(k);
        step(w.wen, w.addr, w.data);
      end
      n_vec++;
      if (flags() !== ef || fail_testnum !== etn || cycle_cnt !== ecnt) begin
        n_err++;
        $display("FAIL random%0d: flags=%b tn=%0h cnt=%0d want %b/%0h/%0d", it, flags(), fail_testnum,
                 cycle_cnt, ef, etn, ecnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_drain_capture();
    test_timeout();
    test_filter();
    test_reset_mid();
    test_clr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
